// File: rtl/restador_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package restador_pkg;

  localparam int unsigned RESTADOR_WIDTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } restador_state_t;

endpackage

// File: rtl/restador_fa.sv
// Combinational 1-bit full adder used as the serial subtract step.
module restador_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum and majority carry.
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/restador_serial.sv
// Bit-serial unsigned subtractor: restador = A - B mod 2^WIDTH, computed as
// A + ~B + 1 one bit per cycle, LSB first. C_out = 1 means no borrow.
module restador_serial
  import restador_pkg::*;
#(
  parameter int unsigned WIDTH = RESTADOR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sel,
  output logic [WIDTH-1:0] restador,
  output logic             C_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  restador_state_t state_q, state_d;
  logic             sel_q;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] restador_q, restador_d;
  logic             c_out_q, c_out_d;
  logic             done_q, done_d;

  logic start;
  logic fa_s, fa_cout;

  assign start = sel & ~sel_q;

  restador_fa u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // Next-state, datapath and output-register updates.
  always_comb begin
    state_d    = state_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    res_sh_d   = res_sh_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    restador_d = restador_q;
    c_out_d    = c_out_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = A;
          b_sh_d  = ~B;
          carry_d = 1'b1;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_sh_d = {fa_s, res_sh_q[WIDTH-1:1]};
        carry_d  = fa_cout;
        cnt_d    = cnt_q + 1'b1;
        // Last step publishes straight from the adder so the outputs
        // update on the same edge that shifts in the final sum bit.
        if (cnt_q == CW'(WIDTH - 1)) begin
          restador_d = {fa_s, res_sh_q[WIDTH-1:1]};
          c_out_d    = fa_cout;
          done_d     = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= 1'b0;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      res_sh_q   <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      restador_q <= '0;
      c_out_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      res_sh_q   <= res_sh_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      restador_q <= restador_d;
      c_out_q    <= c_out_d;
      done_q     <= done_d;
    end
  end

  assign restador = restador_q;
  assign C_out    = c_out_q;
  assign done     = done_q;
  assign busy     = (state_q == SHIFT);

endmodule

// File: tb/tb_restador_serial.sv
// Scoreboard bench for restador_serial: stimulus pushes expected results,
// a monitor pops and compares on every done pulse.
module tb_restador_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] A, B;
  logic       sel;
  logic [3:0] restador;
  logic       C_out, busy, done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [4:0] exp_q[$];   // {C_out, restador}

  restador_serial #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .A        (A),
    .B        (B),
    .sel      (sel),
    .restador (restador),
    .C_out    (C_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && done === 1'b1) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=%0d expected=none", restador);
        end else begin
          logic [4:0] e;
          e = exp_q.pop_front();
          check("restador", int'(restador), int'(e[3:0]));
          check("C_out", int'(C_out), int'(e[4]));
        end
      end
    end
  end

  task automatic push_exp(input logic [3:0] r, input logic c);
    exp_q.push_back({c, r});
  endtask

  // Pulse sel for one cycle with the given operands.
  task automatic pulse(input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    A = a; B = b; sel = 1'b1;
    @(negedge clk);
    sel = 1'b0;
  endtask

  // Wait (bounded) for done; returns cycles counted after the start edge.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL timeout actual=%0d expected=done", n);
    end
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] r, input logic c, input bit chk_lat);
    int n;
    push_exp(r, c);
    pulse(a, b);
    if (chk_lat) check("busy_during", int'(busy), 1);
    wait_done(n);
    if (chk_lat) begin
      check("latency", n, 4);
      check("busy_after", int'(busy), 0);
    end
    @(negedge clk);
  endtask

  initial begin
    int base, n;
    rst = 1'b1; sel = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    check("rst_restador", int'(restador), 0);
    check("rst_C_out", int'(C_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst = 1'b0;

    // Directed vectors.
    run_op(4'd5, 4'd3, 4'd2, 1'b1, 1'b1);
    run_op(4'd3, 4'd5, 4'd14, 1'b0, 1'b1);
    run_op(4'd7, 4'd7, 4'd0, 1'b1, 1'b1);
    run_op(4'd15, 4'd0, 4'd15, 1'b1, 1'b1);
    // Outputs hold after completion.
    repeat (3) @(negedge clk);
    check("hold_restador", int'(restador), 15);
    check("hold_done", int'(done), 0);

    // sel held high for 10 cycles: one operation only.
    base = done_cnt;
    push_exp(4'd5, 1'b1);
    @(negedge clk);
    A = 4'd9; B = 4'd4; sel = 1'b1;
    repeat (10) @(negedge clk);
    sel = 1'b0;
    repeat (4) @(negedge clk);
    check("hold_sel_dones", done_cnt - base, 1);

    // Second rising edge and operand change while busy: ignored.
    base = done_cnt;
    push_exp(4'd5, 1'b1);
    pulse(4'd9, 4'd4);
    pulse(4'd1, 4'd8);
    A = 4'd0; B = 4'd15;
    wait_done(n);
    repeat (6) @(negedge clk);
    check("busy_restart_dones", done_cnt - base, 1);

    // Reset mid-operation aborts with no done.
    base = done_cnt;
    pulse(4'd12, 4'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_restador", int'(restador), 0);
    check("abort_C_out", int'(C_out), 0);
    check("abort_busy", int'(busy), 0);
    repeat (6) @(negedge clk);
    check("abort_dones", done_cnt - base, 0);
    run_op(4'd12, 4'd1, 4'd11, 1'b1, 1'b1);

    // Sweep.
    for (int a = 1; a <= 15; a++) begin
      for (int b = 0; b <= 14; b++) begin
        logic [3:0] r;
        r = 4'(a - b);
        run_op(4'(a), 4'(b), r, (a >= b), 1'b0);
      end
    end

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
